// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch command path:
// command encodings and a width helper.
package cronometro_pkg;

  typedef enum logic [1:0] {
    PARA  = 2'd0,
    PAUSE = 2'd1,
    RESET = 2'd2,
    CONTA = 2'd3
  } comando_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int largura(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// One push-button: synchroniser, debouncer, release
// detector and saturating hold-time counter.
module debounce_botao
  import cronometro_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int LONGO_CICLOS    = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pressionado,
  output logic solto,
  output logic longo_i
);

  localparam int WD = largura(DEBOUNCE_CICLOS + 1);
  localparam int WH = largura(LONGO_CICLOS + 1);
  localparam logic [WD-1:0] DMAX = WD'(DEBOUNCE_CICLOS - 1);
  localparam logic [WH-1:0] HMAX = WH'(LONGO_CICLOS);

  logic          s1;
  logic          s2;
  logic          estavel;
  logic [WD-1:0] cnt;
  logic [WH-1:0] hold;
  logic          vira;

  // estavel keeps the raw polarity: 1 = released
  assign vira        = (s2 != estavel) && (cnt == DMAX);
  assign pressionado = ~estavel;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      estavel <= 1'b1;
      cnt     <= '0;
      hold    <= '0;
      solto   <= 1'b0;
      longo_i <= 1'b0;
    end else begin
      s1      <= botao;
      s2      <= s1;
      solto   <= vira && s2;
      longo_i <= vira && s2 && (hold == HMAX);
      if (s2 == estavel) begin
        cnt <= '0;
      end else if (vira) begin
        cnt     <= '0;
        estavel <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (estavel)
        hold <= '0;
      else if (hold != HMAX)
        hold <= hold + 1'b1;
    end
  end

endmodule

// File: rtl/botoes_comando.sv
// Button command decoder: per-button debounce plus a
// lowest-index-wins release encoder feeding registered outputs.
module botoes_comando
  import cronometro_pkg::*;
#(
  parameter int  N_BOTOES        = 4,
  parameter int  DEBOUNCE_CICLOS = 16,
  parameter int  LONGO_CICLOS    = 1024,
  parameter int  ESTADO_RESET    = 0,
  localparam int W_ESTADO        = largura(N_BOTOES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botao,
  output logic [W_ESTADO-1:0] estado,
  output logic                evento,
  output logic                longo,
  output logic [N_BOTOES-1:0] pressionado
);

  logic [N_BOTOES-1:0] solto;
  logic [N_BOTOES-1:0] longo_v;
  logic                sel_v;
  logic                sel_l;
  logic [W_ESTADO-1:0] sel_i;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_bt
    debounce_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
      .LONGO_CICLOS   (LONGO_CICLOS)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .botao      (botao[g]),
      .pressionado(pressionado[g]),
      .solto      (solto[g]),
      .longo_i    (longo_v[g])
    );
  end

  // descending scan so the lowest index overrides
  always_comb begin
    sel_v = 1'b0;
    sel_l = 1'b0;
    sel_i = '0;
    for (int i = N_BOTOES - 1; i >= 0; i--) begin
      if (solto[i]) begin
        sel_v = 1'b1;
        sel_l = longo_v[i];
        sel_i = W_ESTADO'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= W_ESTADO'(ESTADO_RESET);
      evento <= 1'b0;
      longo  <= 1'b0;
    end else begin
      evento <= sel_v;
      longo  <= sel_l;
      if (sel_v) estado <= sel_i;
    end
  end

endmodule

// File: tb/tb_botoes_comando.sv
// Randomised and directed bench for botoes_comando
// against a timestamp-based behavioural model.
module tb_botoes_comando;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int LONGO = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] botao = '1;
  logic [1:0]   estado;
  logic         evento;
  logic         longo;
  logic [N-1:0] pressionado;

  int n_cmp = 0;
  int n_bad = 0;
  int ev_count = 0;
  bit p1_seen = 0;

  botoes_comando #(
    .N_BOTOES       (N),
    .DEBOUNCE_CICLOS(DEB),
    .LONGO_CICLOS   (LONGO),
    .ESTADO_RESET   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .botao      (botao),
    .estado     (estado),
    .evento     (evento),
    .longo      (longo),
    .pressionado(pressionado)
  );

  always #5 clk = ~clk;

  task automatic check(input string nome, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the synchronised input
  // disagrees for DEB edges in a row; press/release edges are
  // timestamped and the hold length is their difference.
  logic [N-1:0] m_s1, m_s2;
  bit   [N-1:0] m_stab;
  int           m_run   [N];
  int           m_pedge [N];
  int           cyc = 0;
  bit           armed = 0;
  bit           p_any, p_long, lvl;
  int           p_idx;
  int           m_estado;
  bit           m_evento, m_longo;

  always @(posedge clk) begin
    armed = 1;
    cyc++;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stab = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_pedge[i] = 0;
      end
      p_any = 0; p_long = 0; p_idx = 0;
      m_estado = 0; m_evento = 0; m_longo = 0;
    end else begin
      m_evento = p_any;
      m_longo  = p_any && p_long;
      if (p_any) m_estado = p_idx;
      p_any = 0; p_long = 0;
      for (int i = 0; i < N; i++) begin
        lvl = !m_s2[i];
        if (lvl != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_run[i] = 0;
            m_stab[i] = lvl;
            if (lvl) m_pedge[i] = cyc;
            else if (!p_any) begin
              p_any  = 1;
              p_idx  = i;
              p_long = (cyc - m_pedge[i] - 1) >= LONGO;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = botao;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("estado", int'(estado), m_estado);
      check("evento", int'(evento), int'(m_evento));
      check("longo", int'(longo), int'(m_longo));
      check("pressionado", int'(pressionado), int'(m_stab));
      if (evento === 1'b1) ev_count++;
      if (pressionado[1] === 1'b1) p1_seen = 1;
    end
  end

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    botao = v;
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
    botao = '1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int ev0;
  int p;

  initial begin
    // reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      check("idle_outputs", int'({estado, evento, longo, pressionado}), 0);
    end

    // clean press/release of button 3
    drive(4'b0111);
    edges(5);
    check("p3_not_yet", int'(pressionado[3]), 0);
    edges(1);
    check("p3_rise_6", int'(pressionado[3]), 1);
    repeat (3) @(posedge clk);
    drive(4'b1111);
    edges(6);
    check("ev3_not_yet", int'(evento), 0);
    edges(1);
    check("ev3_evento", int'(evento), 1);
    check("ev3_estado", int'(estado), 3);
    check("ev3_longo", int'(longo), 0);
    edges(1);
    check("ev3_one_cycle", int'(evento), 0);
    check("ev3_persist", int'(estado), 3);
    idle(10);

    // bounces on button 1
    ev0 = ev_count;
    p1_seen = 0;
    drive(4'b1101); idle(1);
    repeat (6) @(negedge clk);
    botao = 4'b1101; idle(2);
    repeat (6) @(negedge clk);
    botao = 4'b1101; idle(3);
    idle(15);
    check("bounce_no_press", int'(p1_seen), 0);
    check("bounce_no_event", ev_count - ev0, 0);

    // simultaneous release of 2 and 0
    drive(4'b1010);
    repeat (15) @(negedge clk);
    botao = 4'b1111;
    ev0 = ev_count;
    edges(7);
    check("sim_evento", int'(evento), 1);
    check("sim_estado", int'(estado), 0);
    edges(12);
    check("sim_single", ev_count - ev0, 1);

    // long press then short repeat on button 2
    drive(4'b1011);
    repeat (40) @(negedge clk);
    botao = 4'b1111;
    edges(7);
    check("long_evento", int'(evento), 1);
    check("long_estado", int'(estado), 2);
    check("long_longo", int'(longo), 1);
    drive(4'b1011);
    repeat (10) @(negedge clk);
    botao = 4'b1111;
    edges(7);
    check("short_evento", int'(evento), 1);
    check("short_estado", int'(estado), 2);
    check("short_longo", int'(longo), 0);
    idle(10);

    // reset at debounce count 2 of a release
    drive(4'b1101);
    repeat (10) @(negedge clk);
    botao = 4'b1111;
    ev0 = ev_count;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edges(20);
    check("rst_no_event", ev_count - ev0, 0);
    check("rst_released", int'(pressionado), 0);

    // button held through reset
    drive(4'b1110);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    edges(5);
    check("held_not_yet", int'(pressionado[0]), 0);
    edges(1);
    check("held_rise_6", int'(pressionado[0]), 1);
    @(negedge clk);
    botao = 4'b1111;
    edges(7);
    check("held_evento", int'(evento), 1);
    check("held_estado", int'(estado), 0);
    check("held_longo", int'(longo), 0);
    idle(10);

    // randomised activity, model checks every cycle
    p = 3;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 300 == 0) p = (c % 600 == 0) ? 3 : 40;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, p - 1) == 0) botao[i] = ~botao[i];
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    botao = '1;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
